regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port between three writeback requesters: ALU, mult/div unit, and memory load. Each cycle it grants at most one request and registers the winner's address and data. It drives the port's 32 one-hot write enables, so it is the only agent that sequences the 5-to-32 write-select decode. It sits between the writeback stage and the register file.

## Interface
Parameters:
- NREQ, 3, number of requesters; fixed at 3 in this revision.
- DW, 32, data width.

Ports:
- clock  in  1  rising-edge clock for all state.
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  per-requester write request; bit 0 = ALU, 1 = mult/div, 2 = load.
- addr0, addr1, addr2  in  5 each  destination register of each requester.
- data0, data1, data2  in  32 each  write data of each requester.
- ack  out  3  one-hot grant, combinational, same cycle as the accepted req.
- rf_we  out  32  one-hot register write enable, registered; bit k writes register k.
- rf_addr  out  5  registered destination address.
- rf_data  out  32  registered write data.
- rf_valid  out  1  registered; a granted write is presented this cycle (includes r0 writes).
- grant_id  out  2  registered index of the last granted requester.

## Operation
- Handshake:
  - A requester raises req[i] and holds addr/data stable until it sees ack[i]=1.
  - ack[i] is a single-cycle pulse.
  - After ack, the requester may drop req[i], or present a new request in the next cycle.
- Arbitration:
  - At most one ack bit is high per cycle.
  - If no req bit is high, ack=0 and nothing is registered.
- Priority pointer ptr (2-bit, values 0..2):
  - Search order is ptr, ptr+1, ptr+2, wrapping mod 3.
  - The first asserted req in that order wins.
  - After a grant to requester i, ptr becomes (i+1) mod 3.
  - With no grant, ptr holds.
- Output stage, on the clock edge after a grant to requester i:
  - rf_addr <= addr_i, rf_data <= data_i, rf_valid <= 1, grant_id <= i.
  - rf_we <= one-hot decode of addr_i.
- r0 rule: a request with addr=0 is acked normally and sets rf_valid=1, but rf_we stays all-zero.
- Idle cycles (no grant): rf_valid <= 0 and rf_we <= 0. rf_addr, rf_data and grant_id hold.
- rf_we must be decoded from the same registered address, so it is never non-one-hot: always exactly zero or one bit set.
- No back-pressure exists; the register file accepts one write every cycle.

## Timing
- Reset (resetn=0, asynchronous):
  - Immediately: ptr=0, rf_we=0, rf_addr=0, rf_data=0, rf_valid=0, grant_id=0.
  - While resetn=0, ack is forced to 0.
- Reset mid-handshake: a request whose ack was not yet seen stays pending and is arbitrated normally after resetn rises. An in-flight registered write is discarded.
- Latency: req sampled in cycle t → ack in cycle t → rf_we/rf_data valid throughout cycle t+1.
- Throughput: one write per cycle. Back-to-back grants to different requesters produce writes in consecutive cycles.
- Simultaneous requests: exactly one is acked; the others remain pending with no loss.
- Fairness:
  - With all three requesting continuously, grants rotate, e.g. 0,1,2,0,…
  - Every requester waits at most 2 cycles.
- Same-address collisions across cycles are the requesters' concern; the later grant simply overwrites.

## Configuration
- Macro WB_ARB_ROUND_ROBIN_EN.
- Defined: rotating-pointer arbitration as described above.
- Undefined:
  - ptr is removed; fixed priority applies, req[0] > req[1] > req[2].
  - A continuous ALU request can starve the others; that is accepted.
  - All other behaviour, latency and reset values are identical.

## Test plan
- Reset: hold resetn=0 with req=3'b111 → ack=0, rf_we=0, rf_valid=0. Release → first grant goes to requester 0, since ptr=0.
- Single write: req=3'b010, addr1=5'd17, data1=32'hDEADBEEF → ack=3'b010 the same cycle. Next cycle rf_we=32'h0002_0000, rf_addr=17, rf_data=32'hDEADBEEF, rf_valid=1, grant_id=1.
- Rotation (RR build): req=3'b111 held for 6 cycles → ack sequence 001,010,100,001,010,100, and rf_we follows one cycle later.
- r0 write: req=3'b100, addr2=0, data2=32'h1234 → ack=3'b100; next cycle rf_valid=1, rf_we=0.
- Async reset mid-burst: pull resetn low between clock edges while rf_valid=1 → outputs go to 0 before the next edge. A held request is re-granted after release.
- Fixed priority (macro undefined): req=3'b111 held for 3 cycles → ack=3'b001 every cycle; then req=3'b110 → ack=3'b010.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: grants one of ALU / mult-div / load
// writebacks per cycle. Define WB_ARB_ROUND_ROBIN_EN for rotating priority; otherwise fixed priority.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic [NREQ-1:0] req,
  input  logic [4:0]      addr0,
  input  logic [4:0]      addr1,
  input  logic [4:0]      addr2,
  input  logic [DW-1:0]   data0,
  input  logic [DW-1:0]   data1,
  input  logic [DW-1:0]   data2,
  output logic [NREQ-1:0] ack,
  output logic [31:0]     rf_we,
  output logic [4:0]      rf_addr,
  output logic [DW-1:0]   rf_data,
  output logic            rf_valid,
  output logic [1:0]      grant_id
);

  logic            w_any;
  logic [1:0]      w_id;
  logic [4:0]      w_addr;
  logic [DW-1:0]   w_data;
  logic [NREQ-1:0] w_ack;

  // Register r0 is hardwired, so a write to it is acknowledged but never enabled.
  function automatic logic [31:0] dec_we(input logic [4:0] a);
    logic [31:0] dec;
    dec = '0;
    if (a != 5'd0) dec[a] = 1'b1;
    return dec;
  endfunction

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [1:0] r_ptr;
  logic [2:0] w_rot;
  logic [1:0] w_off;
  logic [2:0] w_sum;

  // Rotate requests so the pointer's requester sits at bit 0, then map back mod 3.
  always_comb begin
    case (r_ptr)
      2'd1:    w_rot = {req[0], req[2], req[1]};
      2'd2:    w_rot = {req[1], req[0], req[2]};
      default: w_rot = req;
    endcase
    w_off = w_rot[0] ? 2'd0 : (w_rot[1] ? 2'd1 : 2'd2);
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    w_id  = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
    w_any = |req;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= 2'd0;
    end else if (w_any) begin
      r_ptr <= (w_id == 2'd2) ? 2'd0 : w_id + 2'd1;
    end
  end
`else
  always_comb begin
    w_id  = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    w_any = |req;
  end
`endif

  always_comb begin
    case (w_id)
      2'd1: begin
        w_addr = addr1;
        w_data = data1;
      end
      2'd2: begin
        w_addr = addr2;
        w_data = data2;
      end
      default: begin
        w_addr = addr0;
        w_data = data0;
      end
    endcase
  end

  always_comb begin
    w_ack = '0;
    if (w_any) w_ack = NREQ'(1) << w_id;
  end

  assign ack = resetn ? w_ack : '0;

  // Output stage: write presented to the register file one cycle after the grant.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= '0;
      rf_addr  <= '0;
      rf_data  <= '0;
      rf_valid <= 1'b0;
      grant_id <= 2'd0;
    end else if (w_any) begin
      rf_we    <= dec_we(w_addr);
      rf_addr  <= w_addr;
      rf_data  <= w_data;
      rf_valid <= 1'b1;
      grant_id <= w_id;
    end else begin
      rf_we    <= '0;
      rf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed steps then randomized
// handshaking requesters, compared against a queue-free behavioural model.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        resetn;
  logic [2:0]  req;
  logic [4:0]  ta [3];
  logic [31:0] td [3];
  logic [2:0]  ack;
  logic [31:0] rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        rf_valid;
  logic [1:0]  grant_id;

  int n_vec;
  int n_err;

  // model state
  int          m_ptr;
  logic [31:0] e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_valid;
  logic [1:0]  e_gid;

  regfile_write_arbiter #(.NREQ(3), .DW(32)) dut (
    .clock(clock), .resetn(resetn), .req(req),
    .addr0(ta[0]), .addr1(ta[1]), .addr2(ta[2]),
    .data0(td[0]), .data1(td[1]), .data2(td[2]),
    .ack(ack), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .rf_valid(rf_valid), .grant_id(grant_id)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [2:0] r);
`ifdef WB_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (r[i]) return i;
    end
`else
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; e_we = '0; e_addr = '0; e_data = '0; e_valid = 1'b0; e_gid = 2'd0;
  endtask

  task automatic model_clock(input int g);
    if (g >= 0) begin
      e_addr  = ta[g];
      e_data  = td[g];
      e_valid = 1'b1;
      e_gid   = 2'(g);
      e_we    = (ta[g] == 5'd0) ? 32'd0 : (32'd1 << ta[g]);
      m_ptr   = (g + 1) % 3;
    end else begin
      e_valid = 1'b0;
      e_we    = '0;
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".rf_valid"}, 64'(rf_valid), 64'(e_valid));
    chk({tag, ".rf_we"},    64'(rf_we),    64'(e_we));
    chk({tag, ".rf_addr"},  64'(rf_addr),  64'(e_addr));
    chk({tag, ".rf_data"},  64'(rf_data),  64'(e_data));
    chk({tag, ".grant_id"}, 64'(grant_id), 64'(e_gid));
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step(input string tag, output int g);
    logic [2:0] e_ack;
    #3;
    g = model_pick(req);
    e_ack = (g < 0) ? 3'b000 : (3'b001 << g);
    chk({tag, ".ack"}, 64'(ack), 64'(e_ack));
    @(posedge clock);
    model_clock(g);
    #1;
    chk_outputs(tag);
  endtask

  initial begin
    int g;
    logic [2:0] pend;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 3; i++) begin
      ta[i] = 5'd0;
      td[i] = 32'd0;
    end
    model_reset();

    // reset held with all requests up
    resetn = 1'b0;
    req = 3'b111;
    #3;
    chk("reset.ack", 64'(ack), 64'd0);
    chk_outputs("reset");
    @(posedge clock);
    #1;
    chk("reset_edge.ack", 64'(ack), 64'd0);
    chk_outputs("reset_edge");
    resetn = 1'b1;

    // first grant after release goes to requester 0
    ta[0] = 5'd3; td[0] = 32'hA5A5_0003;
    ta[1] = 5'd4; td[1] = 32'hA5A5_0004;
    ta[2] = 5'd5; td[2] = 32'hA5A5_0005;
    step("first", g);

    // single write from mult/div
    req = 3'b010; ta[1] = 5'd17; td[1] = 32'hDEADBEEF;
    step("single", g);
    chk("single.we_const", 64'(rf_we), 64'h0002_0000);

    // idle cycle: valid/we clear, address/data hold
    req = 3'b000;
    step("idle", g);

    // r0 write
    req = 3'b100; ta[2] = 5'd0; td[2] = 32'h1234;
    step("r0", g);
    chk("r0.we_zero", 64'(rf_we), 64'd0);

    // all three continuously requesting
    req = 3'b111; ta[0] = 5'd1; ta[1] = 5'd2; ta[2] = 5'd31;
    for (int c = 0; c < 6; c++) step("rotate", g);

    // then drop ALU
    req = 3'b110;
    step("drop_alu", g);

    // async reset between edges while a write is being presented
    req = 3'b111;
    step("preburst", g);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("midrst.ack", 64'(ack), 64'd0);
    chk_outputs("midrst");
    @(posedge clock);
    #1;
    resetn = 1'b1;
    step("regrant", g);

    // randomized requesters obeying the hold-until-ack handshake
    pend = req;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          ta[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
          td[i] = $urandom;
        end
      end
      req = pend;
      if (c == 150) begin
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst.ack", 64'(ack), 64'd0);
        chk_outputs("rnd_rst");
        @(posedge clock);
        #1;
        resetn = 1'b1;
      end
      step("rand", g);
      if (g >= 0) pend[g] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
